// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (src0) and LSU (src1); FRISCV_RF_CLEAR_EN adds a post-reset x1..xN clear sweep.
// Latency: an accepted request appears on rf_we/rf_addr_w/rf_data_w one cycle later.
// Backpressure: srcN_ready is the combinational grant; a losing source holds its request, nothing is buffered.
module regfile_wb_arbiter #(
    parameter int ARCH               = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          src0_valid,
    output logic                          src0_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] src0_addr,
    input  logic [ARCH-1:0]               src0_data,
    input  logic                          src1_valid,
    output logic                          src1_ready,
    input  logic [REGFILE_ADDR_WIDTH-1:0] src1_addr,
    input  logic [ARCH-1:0]               src1_data,
    output logic                          rf_we,
    output logic [REGFILE_ADDR_WIDTH-1:0] rf_addr_w,
    output logic [ARCH-1:0]               rf_data_w,
    output logic                          init_done,
    output logic [CNT_WIDTH-1:0]          conflict_cnt
);

    typedef struct packed {
        logic                          we;
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [ARCH-1:0]               data;
    } wr_t;

    wr_t                           wr_q;
    wr_t                           wr_d;
    logic                          last_grant;
    logic                          run;
    logic                          sweep_active;
    logic [REGFILE_ADDR_WIDTH-1:0] sweep_addr;
    logic                          grant0;
    logic                          grant1;
    logic                          xfer0;
    logic                          xfer1;
    logic [CNT_WIDTH-1:0]          cnt_q;

    // x0 and addresses past the implemented depth are accepted but never written
    function automatic logic addr_ok(input logic [REGFILE_ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < 32'(REGFILE_DEPTH));
    endfunction

`ifdef FRISCV_RF_CLEAR_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [REGFILE_ADDR_WIDTH-1:0] LAST_IDX = REGFILE_ADDR_WIDTH'(REGFILE_DEPTH - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [REGFILE_ADDR_WIDTH-1:0] clr_idx_q;
    logic [REGFILE_ADDR_WIDTH-1:0] clr_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_idx_q <= REGFILE_ADDR_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    assign run          = (state_q == ST_RUN);
    assign sweep_active = (state_q == ST_INIT);
    assign sweep_addr   = clr_idx_q;
`else
    assign run          = 1'b1;
    assign sweep_active = 1'b0;
    assign sweep_addr   = '0;
`endif

    // last_grant holds the index of the most recently accepted source
    assign grant0 = src0_valid && (!src1_valid || last_grant);
    assign grant1 = src1_valid && (!src0_valid || !last_grant);

    assign src0_ready = run && grant0;
    assign src1_ready = run && grant1;
    assign xfer0      = src0_valid && src0_ready;
    assign xfer1      = src1_valid && src1_ready;

    always_comb begin
        wr_d    = wr_q;
        wr_d.we = 1'b0;
        if (sweep_active) begin
            wr_d.we   = 1'b1;
            wr_d.addr = sweep_addr;
            wr_d.data = '0;
        end else if (xfer0) begin
            if (addr_ok(src0_addr)) begin
                wr_d.we   = 1'b1;
                wr_d.addr = src0_addr;
                wr_d.data = src0_data;
            end
        end else if (xfer1) begin
            if (addr_ok(src1_addr)) begin
                wr_d.we   = 1'b1;
                wr_d.addr = src1_addr;
                wr_d.data = src1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            last_grant <= 1'b1;
            cnt_q      <= '0;
        end else begin
            wr_q <= wr_d;
            if (xfer0) begin
                last_grant <= 1'b0;
            end else if (xfer1) begin
                last_grant <= 1'b1;
            end
            if (run && src0_valid && src1_valid && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rf_we        = wr_q.we;
    assign rf_addr_w    = wr_q.addr;
    assign rf_data_w    = wr_q.data;
    assign conflict_cnt = cnt_q;
    assign init_done    = run;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (CNT_WIDTH=4 so saturation is reachable); follows FRISCV_RF_CLEAR_EN when defined.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          s0v;
    logic          s0r;
    logic [AW-1:0] s0a;
    logic [DW-1:0] s0d;
    logic          s1v;
    logic          s1r;
    logic [AW-1:0] s1a;
    logic [DW-1:0] s1d;
    logic          rf_we;
    logic [AW-1:0] rf_addr_w;
    logic [DW-1:0] rf_data_w;
    logic          init_done;
    logic [CW-1:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .ARCH              (DW),
        .REGFILE_ADDR_WIDTH(AW),
        .REGFILE_DEPTH     (32),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src0_valid  (s0v),
        .src0_ready  (s0r),
        .src0_addr   (s0a),
        .src0_data   (s0d),
        .src1_valid  (s1v),
        .src1_ready  (s1r),
        .src1_addr   (s1a),
        .src1_data   (s1d),
        .rf_we       (rf_we),
        .rf_addr_w   (rf_addr_w),
        .rf_data_w   (rf_data_w),
        .init_done   (init_done),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0v = 1'b0;
        s1v = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_done;
`ifdef FRISCV_RF_CLEAR_EN
        exp_done = 1'b0;
`else
        exp_done = 1'b1;
`endif
        rst_n = 1'b0;
        idle();
        s0a = '0; s0d = '0; s1a = '0; s1d = '0;
        #3;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0h expected 0", rf_we); end
        checks++; if (rf_addr_w !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", rf_addr_w); end
        checks++; if (rf_data_w !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h expected 0", rf_data_w); end
        checks++; if (conflict_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0h expected 0", conflict_cnt); end
        checks++; if (init_done !== exp_done) begin failures++; $display("FAIL reset_init_done: got %0h expected %0h", init_done, exp_done); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef FRISCV_RF_CLEAR_EN
    task automatic test_sweep();
        s0v = 1'b1; s0a = 5'd3;
        s1v = 1'b1; s1a = 5'd4;
        #1;
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL sweep_init_low: got %0h expected 0", init_done); end
        for (int i = 1; i <= 31; i++) begin
            checks++; if ({s0r, s1r} !== 2'b00) begin failures++; $display("FAIL sweep_ready idx %0d: got %b expected 00", i, {s0r, s1r}); end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_addr_w !== 5'(i) || rf_data_w !== 32'd0) begin
                failures++;
                $display("FAIL sweep_write idx %0d: got we=%0h addr=%0d data=%0h expected we=1 addr=%0d data=0", i, rf_we, rf_addr_w, rf_data_w, i);
            end
        end
        idle();
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL sweep_init_done: got %0h expected 1", init_done); end
        checks++; if (conflict_cnt !== 4'd0) begin failures++; $display("FAIL sweep_cnt: got %0d expected 0", conflict_cnt); end
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL sweep_after_we: got %0h expected 0", rf_we); end
    endtask
`endif

    task automatic test_conflict();
        logic exp0;
        s0a = 5'd1; s0d = 32'hA0A0_0001;
        s1a = 5'd2; s1d = 32'hB0B0_0002;
        s0v = 1'b1; s1v = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp0 = ((i % 2) == 0);
            checks++;
            if (s0r !== exp0 || s1r !== !exp0) begin
                failures++;
                $display("FAIL conflict_grant cyc %0d: got r0=%0h r1=%0h expected r0=%0h r1=%0h", i, s0r, s1r, exp0, !exp0);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_addr_w !== (exp0 ? 5'd1 : 5'd2) || rf_data_w !== (exp0 ? 32'hA0A0_0001 : 32'hB0B0_0002)) begin
                failures++;
                $display("FAIL conflict_write cyc %0d: got we=%0h addr=%0d data=%0h expected src%0d", i, rf_we, rf_addr_w, rf_data_w, exp0 ? 0 : 1);
            end
        end
        idle();
        #1;
        checks++; if (conflict_cnt !== 4'd4) begin failures++; $display("FAIL conflict_cnt: got %0d expected 4", conflict_cnt); end
    endtask

    task automatic test_single();
        s0v = 1'b1; s0a = 5'd5; s0d = 32'hDEAD_BEEF;
        #1;
        checks++; if (s0r !== 1'b1 || s1r !== 1'b0) begin failures++; $display("FAIL single_ready: got r0=%0h r1=%0h expected r0=1 r1=0", s0r, s1r); end
        tick();
        idle();
        checks++;
        if (rf_we !== 1'b1 || rf_addr_w !== 5'd5 || rf_data_w !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_write: got we=%0h addr=%0d data=%0h expected we=1 addr=5 data=deadbeef", rf_we, rf_addr_w, rf_data_w);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_addr_w !== 5'd5 || rf_data_w !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_hold: got we=%0h addr=%0d data=%0h expected we=0 addr=5 data=deadbeef", rf_we, rf_addr_w, rf_data_w);
        end
    endtask

    task automatic test_x0_drop();
        s1v = 1'b1; s1a = 5'd0; s1d = 32'h0000_1234;
        #1;
        checks++; if (s1r !== 1'b1) begin failures++; $display("FAIL x0_ready: got %0h expected 1", s1r); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_we: got %0h expected 0", rf_we); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] datas [3];
        addrs = '{5'd7, 5'd8, 5'd9};
        datas = '{32'h70, 32'h80, 32'h90};
        for (int i = 0; i < 3; i++) begin
            s1v = 1'b1; s1a = addrs[i]; s1d = datas[i];
            #1;
            checks++; if (s1r !== 1'b1) begin failures++; $display("FAIL b2b_ready %0d: got %0h expected 1", i, s1r); end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_addr_w !== addrs[i] || rf_data_w !== datas[i]) begin
                failures++;
                $display("FAIL b2b_write %0d: got we=%0h addr=%0d data=%0h expected we=1 addr=%0d data=%0h", i, rf_we, rf_addr_w, rf_data_w, addrs[i], datas[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt;
        exp_cnt = 4'd4;
        s0v = 1'b1; s0a = 5'd3; s0d = 32'h33;
        s1v = 1'b1; s1a = 5'd4; s1d = 32'h44;
        #1;
        checks++; if (s0r !== 1'b1 || s1r !== 1'b0) begin failures++; $display("FAIL sat_first_grant: got r0=%0h r1=%0h expected r0=1 r1=0", s0r, s1r); end
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
            checks++; if (conflict_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt cyc %0d: got %0d expected %0d", i, conflict_cnt, exp_cnt); end
        end
        idle();
        tick();
        checks++; if (conflict_cnt !== 4'd15) begin failures++; $display("FAIL sat_final: got %0d expected 15", conflict_cnt); end
    endtask

    task automatic test_reset_mid();
        s0v = 1'b1; s0a = 5'd6; s0d = 32'h66;
        tick();
        idle();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL mid_xfer_we: got %0h expected 1", rf_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_xfer_async_we: got %0h expected 0", rf_we); end
        checks++; if (conflict_cnt !== 4'd0) begin failures++; $display("FAIL mid_xfer_cnt: got %0d expected 0", conflict_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef FRISCV_RF_CLEAR_EN
        for (int i = 0; i < 9; i++) tick();
        checks++; if (rf_addr_w !== 5'd9) begin failures++; $display("FAIL mid_sweep_pos: got %0d expected 9", rf_addr_w); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_sweep_async_we: got %0h expected 0", rf_we); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL mid_sweep_init: got %0h expected 0", init_done); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_addr_w !== 5'd1) begin failures++; $display("FAIL mid_sweep_restart: got we=%0h addr=%0d expected we=1 addr=1", rf_we, rf_addr_w); end
        for (int i = 0; i < 30; i++) tick();
        checks++; if (rf_addr_w !== 5'd31 || init_done !== 1'b1) begin failures++; $display("FAIL mid_sweep_end: got addr=%0d done=%0h expected addr=31 done=1", rf_addr_w, init_done); end
`else
        tick();
        checks++; if (rf_we !== 1'b0 || init_done !== 1'b1) begin failures++; $display("FAIL mid_release_idle: got we=%0h done=%0h expected we=0 done=1", rf_we, init_done); end
`endif
    endtask

    initial begin
        test_reset();
`ifdef FRISCV_RF_CLEAR_EN
        test_sweep();
`endif
        test_conflict();
        test_single();
        test_x0_drop();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
